// File: rtl/stream_decipher_rx.sv
// Receive side of the serial stream-cipher link: hunts for a plaintext sync word,
// then XORs a fixed-length payload with a Galois LFSR keystream and assembles bytes.
module stream_decipher_rx #(
  parameter int unsigned          LFSR_W       = 16,
  parameter logic [LFSR_W-1:0]    SEED         = 16'hACE1,
  parameter logic [LFSR_W-1:0]    TAPS         = 16'hB400,
  parameter int unsigned          SYNC_W       = 8,
  parameter logic [SYNC_W-1:0]    SYNC_WORD    = 8'hD5,
  parameter int unsigned          PAYLOAD_BITS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       resync,
  input  logic       ct_bit,
  input  logic       ct_valid,
  output logic       pt_bit,
  output logic       pt_valid,
  output logic [7:0] pt_byte,
  output logic       byte_valid,
  output logic       locked,
  output logic       frame_done
);

  localparam int unsigned        CNT_W    = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(PAYLOAD_BITS);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  // Only SYNC_W-1 history bits are kept; the live bit completes the window.
  logic [SYNC_W-2:0]   sync_sr_q, sync_sr_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]          byte_sr_q, byte_sr_d;
  logic                pt_bit_q, pt_bit_d;
  logic                pt_valid_q, pt_valid_d;
  logic [7:0]          pt_byte_q, pt_byte_d;
  logic                byte_valid_q, byte_valid_d;
  logic                locked_q, locked_d;
  logic                frame_done_q, frame_done_d;

  logic [SYNC_W-1:0]   sync_window;
  logic                ks;
  logic                pt_next;
  logic [7:0]          byte_next;
  logic [CNT_W-1:0]    cnt_next;

  always_comb begin
    state_d      = state_q;
    sync_sr_d    = sync_sr_q;
    lfsr_d       = lfsr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_sr_d    = byte_sr_q;
    pt_bit_d     = pt_bit_q;
    pt_byte_d    = pt_byte_q;
    pt_valid_d   = 1'b0;
    byte_valid_d = 1'b0;
    frame_done_d = 1'b0;

    sync_window = {sync_sr_q, ct_bit};
    ks          = lfsr_q[0];
    pt_next     = ct_bit ^ ks;
    byte_next   = {byte_sr_q, pt_next};
    cnt_next    = bit_cnt_q + 1'b1;

    // resync wins over a same-cycle ct_valid; that bit is simply dropped.
    if (resync) begin
      state_d   = HUNT;
      sync_sr_d = '0;
      bit_cnt_d = '0;
      byte_sr_d = '0;
      lfsr_d    = SEED;
    end else if (ct_valid) begin
      case (state_q)
        HUNT: begin
          sync_sr_d = sync_window[SYNC_W-2:0];
          if (sync_window == SYNC_WORD) begin
            state_d   = PAYLOAD;
            lfsr_d    = SEED;
            bit_cnt_d = '0;
            byte_sr_d = '0;
          end
        end
        PAYLOAD: begin
          pt_bit_d   = pt_next;
          pt_valid_d = 1'b1;
          lfsr_d     = (lfsr_q >> 1) ^ (ks ? TAPS : '0);
          byte_sr_d  = byte_next[6:0];
          bit_cnt_d  = cnt_next;
          if (cnt_next[2:0] == 3'd0) begin
            pt_byte_d    = byte_next;
            byte_valid_d = 1'b1;
          end
          // Clearing the sync history stops a sync word straddling two frames.
          if (cnt_next == LAST_CNT) begin
            frame_done_d = 1'b1;
            state_d      = HUNT;
            sync_sr_d    = '0;
            bit_cnt_d    = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == PAYLOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      sync_sr_q    <= '0;
      lfsr_q       <= SEED;
      bit_cnt_q    <= '0;
      byte_sr_q    <= '0;
      pt_bit_q     <= 1'b0;
      pt_valid_q   <= 1'b0;
      pt_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_sr_q    <= sync_sr_d;
      lfsr_q       <= lfsr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_sr_q    <= byte_sr_d;
      pt_bit_q     <= pt_bit_d;
      pt_valid_q   <= pt_valid_d;
      pt_byte_q    <= pt_byte_d;
      byte_valid_q <= byte_valid_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pt_bit     = pt_bit_q;
  assign pt_valid   = pt_valid_q;
  assign pt_byte    = pt_byte_q;
  assign byte_valid = byte_valid_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_stream_decipher_rx.sv
// Directed bench for stream_decipher_rx: a default 32-bit-frame instance and an
// 8-bit-frame instance share one stimulus stream; a small keystream model builds ciphertext.
module tb_stream_decipher_rx;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, resync, ctBit, ctValid;

  logic       ptBit, ptValid, byteValid, locked, frameDone;
  logic [7:0] ptByte;
  logic       ptBit8, ptValid8, byteValid8, locked8, frameDone8;
  logic [7:0] ptByte8;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] byteQ[$];
  int frameCnt   = 0;
  int ptValidCnt = 0;
  logic [15:0] modelLfsr;

  stream_decipher_rx u_dut (
    .clk(clk), .reset(reset), .resync(resync), .ct_bit(ctBit), .ct_valid(ctValid),
    .pt_bit(ptBit), .pt_valid(ptValid), .pt_byte(ptByte), .byte_valid(byteValid),
    .locked(locked), .frame_done(frameDone)
  );

  stream_decipher_rx #(.PAYLOAD_BITS(8)) u_dut8 (
    .clk(clk), .reset(reset), .resync(resync), .ct_bit(ctBit), .ct_valid(ctValid),
    .pt_bit(ptBit8), .pt_valid(ptValid8), .pt_byte(ptByte8), .byte_valid(byteValid8),
    .locked(locked8), .frame_done(frameDone8)
  );

  // Log every strobe of the 32-bit instance so whole frames can be checked afterwards.
  always @(negedge clk) begin
    if (byteValid) byteQ.push_back(ptByte);
    if (frameDone) frameCnt++;
    if (ptValid) ptValidCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic v);
    ctBit   = b;
    ctValid = v;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic gap(input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic sendByteRaw(input logic [7:0] val, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      gap(gaps);
      applyStimulus(val[i], 1'b1);
    end
  endtask

  task automatic sendPayload(input logic [31:0] pt, input int nBits, input bit gaps);
    logic ks;
    modelLfsr = SEED;
    for (int i = 0; i < nBits; i++) begin
      ks        = modelLfsr[0];
      modelLfsr = (modelLfsr >> 1) ^ (ks ? TAPS : 16'h0000);
      gap(gaps);
      applyStimulus(pt[31-i] ^ ks, 1'b1);
    end
  endtask

  task automatic checkBytes(input string tag, input logic [31:0] pt, input int base);
    logic [7:0] got;
    for (int k = 0; k < 4; k++) begin
      got = (base + k < byteQ.size()) ? byteQ[base+k] : 8'hxx;
      checkOutput($sformatf("%s_byte%0d", tag, k), {24'h0, got}, {24'h0, pt[31-8*k -: 8]});
    end
  endtask

  task automatic doReset();
    reset   = 1'b0;
    resync  = 1'b0;
    ctBit   = 1'b0;
    ctValid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int bB, fB, pB;
    logic [7:0] syncWord;
    logic [7:0] ct87;
    syncWord = 8'hD5;
    ct87     = 8'h87;

    // Sync plus one byte on the 8-bit-frame instance.
    doReset();
    checkOutput("rst_outputs", {19'h0, ptBit, ptValid, ptByte, byteValid, locked, frameDone}, 32'h0);
    checkOutput("rst_outputs8", {19'h0, ptBit8, ptValid8, ptByte8, byteValid8, locked8, frameDone8}, 32'h0);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(syncWord[i], 1'b1);
      checkOutput($sformatf("t1_lock_%0d", 7 - i), {31'h0, locked8}, {31'h0, (i == 0)});
    end
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(ct87[i], 1'b1);
      checkOutput("t1_ptvalid", {31'h0, ptValid8}, 32'h1);
      checkOutput("t1_ptbit", {31'h0, ptBit8}, 32'h0);
      checkOutput("t1_bv_fd", {30'h0, byteValid8, frameDone8}, (i == 0) ? 32'h3 : 32'h0);
    end
    checkOutput("t1_byte", {24'h0, ptByte8}, 32'h00);
    idle(1);
    checkOutput("t1_unlock", {29'h0, locked8, frameDone8, ptValid8}, 32'h0);

    // Default 32-bit frame.
    doReset();
    bB = byteQ.size(); fB = frameCnt; pB = ptValidCnt;
    sendByteRaw(8'hD5, 1'b0);
    checkOutput("t2_lock", {31'h0, locked}, 32'h1);
    sendPayload(32'hDEADBEEF, 32, 1'b0);
    checkOutput("t2_fdone", {31'h0, frameDone}, 32'h1);
    idle(2);
    checkOutput("t2_nbytes", byteQ.size() - bB, 32'd4);
    checkBytes("t2", 32'hDEADBEEF, bB);
    checkOutput("t2_frames", frameCnt - fB, 32'd1);
    checkOutput("t2_ptvalids", ptValidCnt - pB, 32'd32);
    checkOutput("t2_unlock", {31'h0, locked}, 32'h0);

    // Back-to-back frames.
    doReset();
    bB = byteQ.size(); fB = frameCnt;
    sendByteRaw(8'hD5, 1'b0);
    sendPayload(32'h0123ABCD, 32, 1'b0);
    sendByteRaw(8'hD5, 1'b0);
    sendPayload(32'hD5D5D5D5, 32, 1'b0);
    idle(2);
    checkOutput("t3_nbytes", byteQ.size() - bB, 32'd8);
    checkBytes("t3a", 32'h0123ABCD, bB);
    checkBytes("t3b", 32'hD5D5D5D5, bB + 4);
    checkOutput("t3_frames", frameCnt - fB, 32'd2);
    checkOutput("t3_unlock", {31'h0, locked}, 32'h0);

    // Hunt robustness with near miss and valid gaps.
    doReset();
    bB = byteQ.size(); fB = frameCnt; pB = ptValidCnt;
    sendByteRaw(8'h00, 1'b1);
    sendByteRaw(8'hFF, 1'b1);
    sendByteRaw(8'hD4, 1'b1);
    checkOutput("t4_nolock_d4", {31'h0, locked}, 32'h0);
    for (int i = 7; i >= 1; i--) begin
      gap(1'b1);
      applyStimulus(syncWord[i], 1'b1);
    end
    checkOutput("t4_nolock_7", {31'h0, locked}, 32'h0);
    gap(1'b1);
    applyStimulus(syncWord[0], 1'b1);
    checkOutput("t4_lock", {31'h0, locked}, 32'h1);
    sendPayload(32'hCAFEF00D, 32, 1'b1);
    idle(2);
    checkOutput("t4_nbytes", byteQ.size() - bB, 32'd4);
    checkBytes("t4", 32'hCAFEF00D, bB);
    checkOutput("t4_frames", frameCnt - fB, 32'd1);
    checkOutput("t4_ptvalids", ptValidCnt - pB, 32'd32);

    // Resync after 13 payload bits, coincident with a valid bit.
    doReset();
    bB = byteQ.size(); fB = frameCnt; pB = ptValidCnt;
    sendByteRaw(8'hD5, 1'b0);
    sendPayload(32'hA5C3_9E01, 13, 1'b0);
    resync = 1'b1;
    applyStimulus(1'b1, 1'b1);
    resync = 1'b0;
    checkOutput("t5_after_resync", {28'h0, locked, ptValid, byteValid, frameDone}, 32'h0);
    idle(3);
    checkOutput("t5_nbytes", byteQ.size() - bB, 32'd1);
    checkOutput("t5_byte0", {24'h0, byteQ[byteQ.size()-1]}, 32'hA5);
    checkOutput("t5_frames", frameCnt - fB, 32'd0);
    checkOutput("t5_ptvalids", ptValidCnt - pB, 32'd13);
    bB = byteQ.size(); fB = frameCnt;
    sendByteRaw(8'hD5, 1'b0);
    sendPayload(32'h5A5AC3C3, 32, 1'b0);
    idle(2);
    checkBytes("t5", 32'h5A5AC3C3, bB);
    checkOutput("t5_frames2", frameCnt - fB, 32'd1);

    // Asynchronous reset between clock edges mid-frame.
    doReset();
    sendByteRaw(8'hD5, 1'b0);
    sendPayload(32'hDEADBEEF, 12, 1'b0);
    checkOutput("t6_locked_pre", {31'h0, locked}, 32'h1);
    checkOutput("t6_byte_pre", {24'h0, ptByte}, 32'hDE);
    #2 reset = 1'b0;
    #1 checkOutput("t6_async_outputs", {19'h0, ptBit, ptValid, ptByte, byteValid, locked, frameDone}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bB = byteQ.size(); fB = frameCnt;
    sendByteRaw(8'hD5, 1'b0);
    sendPayload(32'h13579BDF, 32, 1'b0);
    idle(2);
    checkBytes("t6", 32'h13579BDF, bB);
    checkOutput("t6_frames", frameCnt - fB, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/stream_decipher_rx.md
Name: stream_decipher_rx

Overview:
- Receive end of the serial stream-cipher link.
- Accepts a serial ciphertext bit stream with a valid strobe and hunts for an unencrypted sync word.
- On sync: reloads its keystream LFSR to the shared seed, then decrypts a fixed-length payload bit-by-bit (plaintext = ciphertext XOR keystream).
- Emits decrypted bits and assembled bytes, plus lock and frame-done status for the downstream consumer.

Parameters:
- LFSR_W, 16, keystream LFSR width
- SEED, 16'hACE1, LFSR load value at start of each frame; must be nonzero
- TAPS, 16'hB400, Galois feedback mask
- SYNC_W, 8, sync word width
- SYNC_WORD, 8'hD5, sync pattern, compared MSB-first
- PAYLOAD_BITS, 32, payload bits per frame; multiple of 8, ≥8

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- resync  in  1  synchronous abort: drop lock and return to hunt
- ct_bit  in  1  ciphertext / sync bit
- ct_valid  in  1  ct_bit qualifier; one bit accepted per cycle when high
- pt_bit  out  1  decrypted bit
- pt_valid  out  1  one-cycle strobe qualifying pt_bit
- pt_byte  out  8  assembled byte, first payload bit in MSB
- byte_valid  out  1  one-cycle strobe qualifying pt_byte
- locked  out  1  high while in PAYLOAD state
- frame_done  out  1  one-cycle pulse on the last payload bit

Behaviour:
- Reset (reset=0, async): state=HUNT, sync shift reg=0, lfsr=SEED, bit_cnt=0, byte shift reg=0. All outputs 0.
- States: HUNT, PAYLOAD. All outputs are registered.
- HUNT:
  - On each ct_valid, sync_sr <= {sync_sr[SYNC_W-2:0], ct_bit}.
  - If {sync_sr[SYNC_W-2:0], ct_bit} == SYNC_WORD, then next cycle: state=PAYLOAD, locked=1, lfsr=SEED, bit_cnt=0.
  - The matching bit itself produces no pt_valid.
  - Cycles with ct_valid=0 hold all state.
- PAYLOAD, each cycle with ct_valid=1:
  - ks = lfsr[0].
  - pt_bit <= ct_bit ^ ks; pt_valid <= 1 (latency: 1 cycle after the accepting edge).
  - lfsr <= (lfsr >> 1) ^ (ks ? TAPS : 0).
  - Byte shift reg <= {sr[6:0], pt}; bit_cnt++.
  - On every 8th payload bit: pt_byte <= completed byte and byte_valid <= 1, in the same cycle as that bit's pt_valid.
  - On bit PAYLOAD_BITS:
    - frame_done <= 1 alongside the final pt_valid/byte_valid.
    - Next state HUNT; locked <= 0.
    - sync_sr cleared to 0, so sync bits cannot straddle frames.
    - lfsr reloads only on the next sync.
- pt_byte holds its value between byte_valid strobes. pt_bit holds its value between strobes.
- ct_valid gaps in PAYLOAD: LFSR and counters freeze; strobes stay low.
- resync=1 (any state):
  - Next state HUNT; sync_sr, bit_cnt and byte shift reg cleared; lfsr=SEED.
  - locked=0; no frame_done; no strobes that cycle.
  - resync has priority over a simultaneous ct_valid, whose bit is discarded.
- Async reset mid-frame: immediate return to the reset state; any partial byte is discarded.
- A sync pattern appearing inside the payload is treated as data and is not re-detected.
- bit_cnt width: $clog2(PAYLOAD_BITS+1).

Test Plan:
- Sync plus one byte:
  - Stimulus: PAYLOAD_BITS=8. Feed 1,1,0,1,0,1,0,1 (0xD5), then ciphertext 1,0,0,0,0,1,1,1 (0x87 = first 8 keystream bits from 0xACE1).
  - Required: locked rises the cycle after the 8th sync bit; 8 pt_valid pulses, all pt_bit=0; byte_valid with pt_byte=0x00; frame_done on the same cycle; locked falls the next cycle.
- Default 32-bit frame:
  - Stimulus: sync, then ciphertext = plaintext 0xDEADBEEF XOR keystream, computed by the bench model.
  - Required: byte_valid four times with 0xDE, 0xAD, 0xBE, 0xEF; one frame_done.
- Back-to-back frames:
  - Stimulus: two sync+payload frames sent contiguously.
  - Required: both decrypt correctly, since the LFSR reloads to SEED at each sync; no false lock from payload bits.
- Hunt robustness:
  - Stimulus: random preamble containing a near-miss 0xD4, then 0xD5, with ct_valid toggling randomly throughout.
  - Required: lock only after 0xD5; decrypted data is unaffected by the gaps.
- Resync mid-payload:
  - Stimulus: assert resync after 13 payload bits, in the same cycle as a ct_valid bit.
  - Required: locked=0, no frame_done, no byte_valid for the partial byte; the next full frame decrypts correctly.
- Async reset mid-frame:
  - Stimulus: drop reset between clock edges.
  - Required: all outputs go to 0 immediately, state=HUNT; correct operation after release.
